// File: rtl/up_counter8_mod.sv
`default_nettype none
// ============================================================================
// Module   : up_counter8_mod
// Brief    : Loadable up counter with a programmable terminal value (limit),
//            one-shot (halt at limit) and auto-reload (wrap to 0) modes.
//            A RUN/HALT control FSM decides whether counting continues
//            once the terminal value is reached.
// Revision : 1.0 - initial release
// ============================================================================
module up_counter8_mod #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             w_match;

  // Terminal compare is live against the current limit input every cycle.
  assign w_match = (count_q == limit);

  // Next-state logic: load beats counting; HALT freezes the count until load.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = data_in;
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && enable) begin
      if (!w_match) begin
        // Natural FF->00 rollover is intentional and never flags wrap.
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (auto_reload) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        state_d = S_HALT;
      end
    end
  end

  // State, count and wrap registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tc    = w_match;
  assign wrap  = wrap_q;
  assign done  = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_up_counter8_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_counter8_mod
// Brief    : Table-driven self-checking bench for up_counter8_mod plus a
//            hand-written sequence for a mid-count limit change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_counter8_mod;

  logic       clk;
  logic       rst;
  logic       load;
  logic       enable;
  logic       auto_reload;
  logic [7:0] data_in;
  logic [7:0] limit;
  logic [7:0] count;
  logic       tc;
  logic       wrap;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  up_counter8_mod #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .enable      (enable),
    .auto_reload (auto_reload),
    .data_in     (data_in),
    .limit       (limit),
    .count       (count),
    .tc          (tc),
    .wrap        (wrap),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic       en;
    logic       ar;
    logic [7:0] din;
    logic [7:0] lim;
    logic [7:0] e_count;
    logic       e_tc;
    logic       e_wrap;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic r, logic ld, logic en, logic ar,
                              logic [7:0] din, logic [7:0] lim, logic [7:0] ec,
                              logic et, logic ew, logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.load = ld; v.en = en; v.ar = ar;
    v.din = din; v.lim = lim; v.e_count = ec; v.e_tc = et; v.e_wrap = ew; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [7:0] ec, logic et, logic ew, logic ed);
    n_tests++;
    if (count !== ec || tc !== et || wrap !== ew || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got count=%h tc=%b wrap=%b done=%b, expected count=%h tc=%b wrap=%b done=%b",
               name, count, tc, wrap, done, ec, et, ew, ed);
    end
  endtask

  initial begin
    logic [7:0] model;
    logic       wrap_seen;
    int         steps;

    rst = 1'b1; load = 1'b0; enable = 1'b0; auto_reload = 1'b0;
    data_in = 8'h00; limit = 8'h05;

    //   name            rst ld en ar din    lim    count  tc wrap done
    add("reset0",        1, 0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 0, 0);
    add("reset1",        1, 0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 0, 0);
    add("reset_lim0",    1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    add("os_load03",     0, 1, 0, 0, 8'h03, 8'h05, 8'h03, 0, 0, 0);
    add("os_04",         0, 0, 1, 0, 8'h00, 8'h05, 8'h04, 0, 0, 0);
    add("os_05_tc",      0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 1, 0, 0);
    add("os_halt",       0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 1, 0, 1);
    add("os_hold1",      0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 1, 0, 1);
    add("os_hold2",      0, 0, 1, 1, 8'h00, 8'h05, 8'h05, 1, 0, 1);
    add("os_hold3",      0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 1, 0, 1);
    add("restart_ld01",  0, 1, 0, 0, 8'h01, 8'h05, 8'h01, 0, 0, 0);
    add("restart_02",    0, 0, 1, 0, 8'h00, 8'h05, 8'h02, 0, 0, 0);
    add("prio_ld_en",    0, 1, 1, 0, 8'h0A, 8'h05, 8'h0A, 0, 0, 0);
    add("prio_rst_ld",   1, 1, 1, 0, 8'h0A, 8'h05, 8'h00, 0, 0, 0);
    add("ar_01",         0, 0, 1, 1, 8'h00, 8'h02, 8'h01, 0, 0, 0);
    add("ar_02",         0, 0, 1, 1, 8'h00, 8'h02, 8'h02, 1, 0, 0);
    add("ar_wrap_a",     0, 0, 1, 1, 8'h00, 8'h02, 8'h00, 0, 1, 0);
    add("ar_01b",        0, 0, 1, 1, 8'h00, 8'h02, 8'h01, 0, 0, 0);
    add("ar_02b",        0, 0, 1, 1, 8'h00, 8'h02, 8'h02, 1, 0, 0);
    add("ar_wrap_b",     0, 0, 1, 1, 8'h00, 8'h02, 8'h00, 0, 1, 0);
    add("ar_idle",       0, 0, 0, 1, 8'h00, 8'h02, 8'h00, 0, 0, 0);
    add("ro_ldFE",       0, 1, 0, 0, 8'hFE, 8'h01, 8'hFE, 0, 0, 0);
    add("ro_FF",         0, 0, 1, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 0);
    add("ro_00",         0, 0, 1, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    add("ro_01",         0, 0, 1, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);
    add("ro_halt",       0, 0, 1, 0, 8'h00, 8'h01, 8'h01, 1, 0, 1);
    add("rst_in_halt",   1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    add("lim0_wrap1",    0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    add("lim0_wrap2",    0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; load = vecs[i].load; enable = vecs[i].en;
      auto_reload = vecs[i].ar; data_in = vecs[i].din; limit = vecs[i].lim;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_wrap, vecs[i].e_done);
    end

    // Limit lowered below the running count: must roll over to reach it.
    rst = 1'b0; load = 1'b1; enable = 1'b0; auto_reload = 1'b0;
    data_in = 8'h05; limit = 8'h09;
    @(posedge clk); #1;
    check("lc_load05", 8'h05, 1'b0, 1'b0, 1'b0);

    load = 1'b0; enable = 1'b1; limit = 8'h03;
    model = 8'h05; wrap_seen = 1'b0; steps = 0;
    while (count != 8'h03 && steps < 300) begin
      @(posedge clk); #1;
      model = model + 8'h01;
      steps++;
      if (wrap) wrap_seen = 1'b1;
    end
    n_tests++;
    if (steps != 254 || model != 8'h03) begin
      n_fail++;
      $display("FAIL lc_steps: got %0d edges to reach limit, expected 254", steps);
    end
    n_tests++;
    if (wrap_seen) begin
      n_fail++;
      $display("FAIL lc_wrap: got wrap=1 during rollover, expected wrap=0");
    end
    check("lc_at_limit", 8'h03, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lc_halt", 8'h03, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
